efuse_macro_seq: RTL and testbench

Low-level sequencer between the eFuse read/write controller and the 256-bit eFuse macro, organised as 32 bytes × 8. It accepts a single-cycle read or write request for one NR-bit or NW-bit slice. It then drives the macro pins (CSB, PGENB, LOAD, STROBE, address) with register-programmable setup, strobe and hold times. It returns a done pulse, with read data on reads, and holds busy for the whole operation.

---
 rtl/efuse_macro_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_efuse_macro_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/efuse_macro_seq.sv
// Pin-level sequencer for a 32x8 eFuse macro: reads NR-bit slices byte by byte and
// programs NW-bit slices one blown bit at a time, with programmable phase timing.
module efuse_macro_seq #(
  parameter int NR = 64,
  parameter int NW = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        read_start,
  input  logic [$clog2(256/NR)-1:0]   read_sel,
  output logic                        read_done,
  output logic [NR-1:0]               read_data,
  output logic                        efuse_busy_read,
  input  logic                        write_start,
  input  logic [$clog2(256/NW)-1:0]   write_sel,
  input  logic [NW-1:0]               write_data,
  output logic                        write_done,
  output logic                        efuse_busy_write,
  input  logic [3:0]                  rg_t_setup,
  input  logic [7:0]                  rg_t_rd_strobe,
  input  logic [15:0]                 rg_t_pgm_strobe,
  input  logic [3:0]                  rg_t_hold,
  output logic                        efuse_csb,
  output logic                        efuse_pgenb,
  output logic                        efuse_load,
  output logic                        efuse_strobe,
  output logic [7:0]                  efuse_addr,
  input  logic [7:0]                  efuse_q
);

  localparam int NB  = NR / 8;
  localparam int RSW = $clog2(256/NR);
  localparam int WSW = $clog2(256/NW);
  localparam logic [7:0] NB_LAST = 8'(NB - 1);
  localparam logic [7:0] NW_LAST = 8'(NW - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]     state_reg, state_next;
  logic           op_wr_reg, op_wr_next;
  logic [RSW-1:0] rsel_reg, rsel_next;
  logic [WSW-1:0] wsel_reg, wsel_next;
  logic [3:0]     ts_reg, ts_next;
  logic [7:0]     tr_reg, tr_next;
  logic [15:0]    tw_reg, tw_next;
  logic [3:0]     th_reg, th_next;
  logic [NW-1:0]  wshift_reg, wshift_next;
  logic [7:0]     idx_reg, idx_next;
  logic [15:0]    timer_reg, timer_load;
  logic [7:0]     addr_reg, addr_calc;
  logic [7:0]     rbyte_reg [NB];
  logic           accept_rd, capture, tdone, pin_active;
  logic           csb_reg, pgenb_reg, load_reg, strobe_reg;
  logic           rd_done_reg, wr_done_reg, busy_rd_reg, busy_wr_reg;

  assign tdone = (timer_reg == 16'd0);

  always_comb begin
    state_next  = state_reg;
    op_wr_next  = op_wr_reg;
    rsel_next   = rsel_reg;
    wsel_next   = wsel_reg;
    ts_next     = ts_reg;
    tr_next     = tr_reg;
    tw_next     = tw_reg;
    th_next     = th_reg;
    wshift_next = wshift_reg;
    idx_next    = idx_reg;
    accept_rd   = 1'b0;
    capture     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (read_start || write_start) begin
          ts_next  = rg_t_setup;
          tr_next  = rg_t_rd_strobe;
          tw_next  = rg_t_pgm_strobe;
          th_next  = rg_t_hold;
          idx_next = 8'd0;
        end
        // Read has priority; a coincident write is simply not taken.
        if (read_start) begin
          accept_rd  = 1'b1;
          op_wr_next = 1'b0;
          rsel_next  = read_sel;
          state_next = S_SETUP;
        end else if (write_start) begin
          op_wr_next  = 1'b1;
          wsel_next   = write_sel;
          wshift_next = write_data;
          state_next  = S_SCAN;
        end
      end
      S_SCAN: begin
        if (wshift_reg[0]) begin
          state_next = S_SETUP;
        end else begin
          wshift_next = wshift_reg >> 1;
          if (idx_reg == NW_LAST) state_next = S_DONE;
          else                    idx_next   = idx_reg + 8'd1;
        end
      end
      S_SETUP: begin
        if (tdone) state_next = S_STROBE;
      end
      S_STROBE: begin
        if (tdone) begin
          state_next = S_HOLD;
          capture    = !op_wr_reg;
        end
      end
      S_HOLD: begin
        if (tdone) begin
          if (!op_wr_reg) begin
            state_next = S_NEXT;
          end else begin
            wshift_next = wshift_reg >> 1;
            if (idx_reg == NW_LAST) begin
              state_next = S_DONE;
            end else begin
              idx_next   = idx_reg + 8'd1;
              state_next = S_SCAN;
            end
          end
        end
      end
      S_NEXT: begin
        if (idx_reg == NB_LAST) begin
          state_next = S_DONE;
        end else begin
          idx_next   = idx_reg + 8'd1;
          state_next = S_SETUP;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Each phase counts down from its programmed (length - 1) value.
  always_comb begin
    timer_load = 16'd0;
    case (state_next)
      S_SETUP:  timer_load = {12'd0, ts_next};
      S_STROBE: timer_load = op_wr_next ? tw_next : {8'd0, tr_next};
      S_HOLD:   timer_load = {12'd0, th_next};
      default:  timer_load = 16'd0;
    endcase
  end

  assign addr_calc  = op_wr_next ? (8'(wsel_next) * 8'(NW) + idx_next)
                                 : (8'(rsel_next) * 8'(NB) + idx_next);
  assign pin_active = (state_next == S_SETUP) || (state_next == S_STROBE) ||
                      (state_next == S_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      op_wr_reg   <= 1'b0;
      rsel_reg    <= '0;
      wsel_reg    <= '0;
      ts_reg      <= 4'd0;
      tr_reg      <= 8'd0;
      tw_reg      <= 16'd0;
      th_reg      <= 4'd0;
      wshift_reg  <= '0;
      idx_reg     <= 8'd0;
      timer_reg   <= 16'd0;
      addr_reg    <= 8'd0;
      csb_reg     <= 1'b1;
      pgenb_reg   <= 1'b1;
      load_reg    <= 1'b1;
      strobe_reg  <= 1'b0;
      rd_done_reg <= 1'b0;
      wr_done_reg <= 1'b0;
      busy_rd_reg <= 1'b0;
      busy_wr_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_wr_reg  <= op_wr_next;
      rsel_reg   <= rsel_next;
      wsel_reg   <= wsel_next;
      ts_reg     <= ts_next;
      tr_reg     <= tr_next;
      tw_reg     <= tw_next;
      th_reg     <= th_next;
      wshift_reg <= wshift_next;
      idx_reg    <= idx_next;
      if (state_next != state_reg) timer_reg <= timer_load;
      else if (!tdone)             timer_reg <= timer_reg - 16'd1;
      if (state_next == S_SETUP && state_reg != S_SETUP) addr_reg <= addr_calc;
      // Pins are decoded from the next state so they line up with the state register.
      csb_reg     <= !pin_active;
      pgenb_reg   <= !(pin_active && op_wr_next);
      load_reg    <= !(pin_active && op_wr_next);
      strobe_reg  <= (state_next == S_STROBE);
      rd_done_reg <= (state_next == S_DONE) && !op_wr_next;
      wr_done_reg <= (state_next == S_DONE) && op_wr_next;
      busy_rd_reg <= (state_next != S_IDLE) && !op_wr_next;
      busy_wr_reg <= (state_next != S_IDLE) && op_wr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) rbyte_reg[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (accept_rd)                           rbyte_reg[i] <= 8'd0;
        else if (capture && idx_reg == 8'(i))    rbyte_reg[i] <= efuse_q;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_rd_byte
      assign read_data[8*gi +: 8] = rbyte_reg[gi];
    end
  endgenerate

  assign efuse_csb        = csb_reg;
  assign efuse_pgenb      = pgenb_reg;
  assign efuse_load       = load_reg;
  assign efuse_strobe     = strobe_reg;
  assign efuse_addr       = addr_reg;
  assign read_done        = rd_done_reg;
  assign write_done       = wr_done_reg;
  assign efuse_busy_read  = busy_rd_reg;
  assign efuse_busy_write = busy_wr_reg;

endmodule

// File: tb/tb_efuse_macro_seq.sv
// Directed bench for efuse_macro_seq; the macro model returns 0xA0 + byte address.
module tb_efuse_macro_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_start, write_start;
  logic [1:0]  read_sel, write_sel;
  logic [63:0] write_data;
  logic [3:0]  rg_t_setup, rg_t_hold;
  logic [7:0]  rg_t_rd_strobe;
  logic [15:0] rg_t_pgm_strobe;
  logic        read_done, write_done, efuse_busy_read, efuse_busy_write;
  logic [63:0] read_data;
  logic        efuse_csb, efuse_pgenb, efuse_load, efuse_strobe;
  logic [7:0]  efuse_addr, efuse_q;

  efuse_macro_seq #(.NR(64), .NW(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_start(read_start), .read_sel(read_sel), .read_done(read_done),
    .read_data(read_data), .efuse_busy_read(efuse_busy_read),
    .write_start(write_start), .write_sel(write_sel), .write_data(write_data),
    .write_done(write_done), .efuse_busy_write(efuse_busy_write),
    .rg_t_setup(rg_t_setup), .rg_t_rd_strobe(rg_t_rd_strobe),
    .rg_t_pgm_strobe(rg_t_pgm_strobe), .rg_t_hold(rg_t_hold),
    .efuse_csb(efuse_csb), .efuse_pgenb(efuse_pgenb), .efuse_load(efuse_load),
    .efuse_strobe(efuse_strobe), .efuse_addr(efuse_addr), .efuse_q(efuse_q)
  );

  assign efuse_q = 8'hA0 + efuse_addr;

  always #5 clk = ~clk;

  // Free-running cycle count and a negedge monitor logging strobes, dones and busy cycles.
  int   cyc_abs = 0;
  int   n_strb = 0, rd_done_n = 0, wr_done_n = 0, rd_done_at = 0, wr_done_at = 0, bw_cnt = 0;
  int   strb_addr [0:31];
  int   strb_len  [0:31];
  logic strb_pg   [0:31];
  logic strb_ld   [0:31];
  logic prev_strobe = 1'b0;

  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  always @(negedge clk) begin
    if (efuse_strobe && !prev_strobe && n_strb < 32) begin
      strb_addr[n_strb] <= int'(efuse_addr);
      strb_len[n_strb]  <= 1;
      strb_pg[n_strb]   <= efuse_pgenb;
      strb_ld[n_strb]   <= efuse_load;
      n_strb            <= n_strb + 1;
    end else if (efuse_strobe && prev_strobe && n_strb > 0) begin
      strb_len[n_strb-1] <= strb_len[n_strb-1] + 1;
    end
    prev_strobe <= efuse_strobe;
    if (read_done)  begin rd_done_n <= rd_done_n + 1; rd_done_at <= cyc_abs; end
    if (write_done) begin wr_done_n <= wr_done_n + 1; wr_done_at <= cyc_abs; end
    if (efuse_busy_write) bw_cnt <= bw_cnt + 1;
  end

  int n_pass = 0, n_chk = 0, t0 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_read(input logic [1:0] sel);
    read_sel = sel; read_start = 1'b1; t0 = cyc_abs;
    step(1);
    read_start = 1'b0;
  endtask

  task automatic start_write(input logic [1:0] sel, input logic [63:0] data);
    write_sel = sel; write_data = data; write_start = 1'b1; t0 = cyc_abs;
    step(1);
    write_start = 1'b0;
  endtask

  // Returns the done cycle relative to the accept cycle, or -1 if it never came.
  task automatic wait_done(input bit rd, input int budget, output int rel);
    int base;
    base = rd ? rd_done_n : wr_done_n;
    rel = -1;
    for (int k = 0; k < budget; k++) begin
      step(1);
      if ((rd ? rd_done_n : wr_done_n) != base) begin
        rel = (rd ? rd_done_at : wr_done_at) - t0;
        break;
      end
    end
  endtask

  task automatic set_timing(input logic [3:0] ts, input logic [7:0] tr,
                            input logic [15:0] tw, input logic [3:0] th);
    rg_t_setup = ts; rg_t_rd_strobe = tr; rg_t_pgm_strobe = tw; rg_t_hold = th;
  endtask

  initial begin
    int rel, s0, w0, r0, b0;
    rst_n = 1'b0; read_start = 1'b0; write_start = 1'b0;
    read_sel = 2'd0; write_sel = 2'd0; write_data = 64'd0;
    set_timing(4'd0, 8'd0, 16'd0, 4'd0);
    step(3);
    chk("rst_csb",    64'(efuse_csb), 64'd1);
    chk("rst_pgenb",  64'(efuse_pgenb), 64'd1);
    chk("rst_load",   64'(efuse_load), 64'd1);
    chk("rst_strobe", 64'(efuse_strobe), 64'd0);
    chk("rst_addr",   64'(efuse_addr), 64'd0);
    chk("rst_rdata",  read_data, 64'd0);
    chk("rst_busy",   64'({efuse_busy_read, efuse_busy_write}), 64'd0);
    chk("rst_done",   64'({read_done, write_done}), 64'd0);
    rst_n = 1'b1;
    step(2);

    // Read slice 3: bytes 24..31, 8 cycles per byte.
    set_timing(4'd1, 8'd2, 16'd0, 4'd1);
    s0 = n_strb;
    start_read(2'd3);
    chk("rd_busy_c1", 64'({efuse_busy_read, efuse_busy_write}), 64'b10);
    wait_done(1'b1, 200, rel);
    $display("read  sel=3 data=%h done@%0d", read_data, rel);
    chk("rd_done_cyc", 64'(rel), 64'd65);
    chk("rd_data", read_data, 64'hBFBEBDBCBBBAB9B8);
    chk("rd_nstrobe", 64'(n_strb - s0), 64'd8);
    chk("rd_addr_first", 64'(strb_addr[s0]), 64'd24);
    chk("rd_addr_last", 64'(strb_addr[s0+7]), 64'd31);
    chk("rd_strb_len0", 64'(strb_len[s0]), 64'd3);
    chk("rd_strb_len7", 64'(strb_len[s0+7]), 64'd3);
    chk("rd_pgenb_load", 64'({strb_pg[s0], strb_ld[s0]}), 64'b11);
    step(3);

    // Write slice 2 with bits 0 and 2 set.
    set_timing(4'd1, 8'd0, 16'd9, 4'd1);
    s0 = n_strb;
    start_write(2'd2, 64'h5);
    chk("wr_busy_c1", 64'({efuse_busy_read, efuse_busy_write}), 64'b01);
    wait_done(1'b0, 300, rel);
    $display("write sel=2 data=%h done@%0d", 64'h5, rel);
    chk("wr_done_cyc", 64'(rel), 64'd93);
    chk("wr_nstrobe", 64'(n_strb - s0), 64'd2);
    chk("wr_addr0", 64'(strb_addr[s0]), 64'd128);
    chk("wr_addr1", 64'(strb_addr[s0+1]), 64'd130);
    chk("wr_len0", 64'(strb_len[s0]), 64'd10);
    chk("wr_len1", 64'(strb_len[s0+1]), 64'd10);
    chk("wr_pgenb_load", 64'({strb_pg[s0], strb_ld[s0], strb_pg[s0+1], strb_ld[s0+1]}), 64'd0);
    step(3);

    // All-zero write: pure scan, no strobes.
    s0 = n_strb; b0 = bw_cnt;
    start_write(2'd1, 64'd0);
    wait_done(1'b0, 200, rel);
    step(2);
    $display("write sel=1 data=%h done@%0d", 64'd0, rel);
    chk("wz_done_cyc", 64'(rel), 64'd65);
    chk("wz_nstrobe", 64'(n_strb - s0), 64'd0);
    chk("wz_busy_cycles", 64'(bw_cnt - b0), 64'd65);

    // Simultaneous starts: only the read runs; a mid-read start is ignored.
    set_timing(4'd0, 8'd0, 16'd0, 4'd0);
    w0 = wr_done_n; r0 = rd_done_n; b0 = bw_cnt;
    read_sel = 2'd0; write_sel = 2'd0; write_data = 64'hFF;
    read_start = 1'b1; write_start = 1'b1; t0 = cyc_abs;
    step(1);
    read_start = 1'b0; write_start = 1'b0;
    step(4);
    read_sel = 2'd1; read_start = 1'b1;
    step(1);
    read_start = 1'b0;
    wait_done(1'b1, 200, rel);
    step(40);
    $display("read  sel=0 data=%h done@%0d (concurrent write dropped)", read_data, rel);
    chk("sim_done_cyc", 64'(rel), 64'd33);
    chk("sim_rdata", read_data, 64'hA7A6A5A4A3A2A1A0);
    chk("sim_rd_count", 64'(rd_done_n - r0), 64'd1);
    chk("sim_wr_count", 64'(wr_done_n - w0), 64'd0);
    chk("sim_wr_busy", 64'(bw_cnt - b0), 64'd0);

    // Back-to-back reads: second request on the first IDLE cycle after read_done.
    start_read(2'd1);
    wait_done(1'b1, 200, rel);
    $display("read  sel=1 data=%h done@%0d", read_data, rel);
    chk("b2b_done1", 64'(rel), 64'd33);
    chk("b2b_rdata1", read_data, 64'hAFAEADACABAAA9A8);
    start_read(2'd2);
    chk("b2b_clear", read_data, 64'd0);
    chk("b2b_busy", 64'(efuse_busy_read), 64'd1);
    wait_done(1'b1, 200, rel);
    $display("read  sel=2 data=%h done@%0d", read_data, rel);
    chk("b2b_done2", 64'(rel), 64'd33);
    chk("b2b_rdata2", read_data, 64'hB7B6B5B4B3B2B1B0);
    step(3);

    // Reset in the middle of a program strobe.
    set_timing(4'd1, 8'd0, 16'd20, 4'd1);
    w0 = wr_done_n;
    start_write(2'd0, 64'h1);
    step(9);
    chk("mid_strobe_on", 64'(efuse_strobe), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("write sel=0 data=%h aborted by reset", 64'h1);
    chk("ar_strobe", 64'(efuse_strobe), 64'd0);
    chk("ar_csb_pgenb", 64'({efuse_csb, efuse_pgenb, efuse_load}), 64'b111);
    chk("ar_busy", 64'({efuse_busy_read, efuse_busy_write}), 64'd0);
    chk("ar_addr", 64'(efuse_addr), 64'd0);
    step(3);
    rst_n = 1'b1;
    step(60);
    chk("ar_no_done", 64'(wr_done_n - w0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
